instruction_sequencer: RTL and testbench
========================================

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 Parameter AddressWidth, default 8: width of the program address.
REQ-002 Parameter RegAddressWidth, default 3: register index width, giving 2**RegAddressWidth registers.
REQ-003 Port Clock, input, 1: sole clock; all state updates on rising edge.
REQ-004 Port nReset, input, 1: reset, asynchronous, active-low.
REQ-005 Port Start, input, 1: single-cycle request to begin execution at StartAddress.
REQ-006 Port StartAddress, input, AddressWidth: program counter load value, sampled with Start.
REQ-007 Port Stop, input, 1: request to return to IDLE after the current instruction.
REQ-008 Port FetchRequest, output, 1: instruction fetch request.
REQ-009 Port FetchAddress, output, AddressWidth: program counter.
REQ-010 Port FetchAck, input, 1: instruction memory acknowledge; FetchData valid this cycle.
REQ-011 Port FetchData, input, InstructionWidth: instruction word.
REQ-012 Port AluOperation, output, eOperation: decoded operation driven to the ALU.
REQ-013 Port AluInFlags, output, sFlags: current flags register.
REQ-014 Port AluInImm, output, ImmediateWidth: immediate field.
REQ-015 Port AluInSrc, output, DataWidth: source register value.
REQ-016 Port AluInDest, output, DataWidth: destination register value.
REQ-017 Port AluOutDest, input, DataWidth: ALU result.
REQ-018 Port AluOutFlags, input, sFlags: ALU flags.
REQ-019 Port Busy, output, 1: high in every state except IDLE.
REQ-020 Port IllegalOp, output, 1: one-cycle pulse when an undefined opcode is retired.
REQ-021 Port DebugAddr, input, RegAddressWidth: register file read index.
REQ-022 Port DebugData, output, DataWidth: combinational read of register[DebugAddr].

Function
REQ-023 The FSM SHALL have states IDLE, FETCH, EXECUTE and WRITEBACK.
REQ-024 IDLE->FETCH on Start with Stop low, loading the program counter (PC) from StartAddress; Start is ignored outside IDLE.
REQ-025 In FETCH, FetchRequest SHALL be 1 and FetchAddress SHALL hold PC stable until FetchAck.
REQ-026 On FetchAck, FetchData SHALL be captured into an instruction register and the FSM SHALL go to EXECUTE.
REQ-027 In EXECUTE, Alu* outputs SHALL be driven from the registered instruction fields, the register file and the flags register.
REQ-028 Alu* outputs SHALL be held through WRITEBACK and SHALL be zero in IDLE and FETCH.
REQ-029 In WRITEBACK, AluOutDest SHALL be written to register[dest] and AluOutFlags to the flags register on the exiting edge.
REQ-030 PC SHALL increment modulo 2**AddressWidth on leaving WRITEBACK; 2**AddressWidth-1 wraps to 0.
REQ-031 WRITEBACK SHALL go to IDLE if Stop was seen at any time since FETCH began, otherwise to FETCH.
REQ-032 Minimum instruction latency is 3 cycles (FETCH with same-cycle ack, EXECUTE, WRITEBACK).
REQ-033 An undefined opcode SHALL suppress the register and flag writes, pulse IllegalOp in WRITEBACK, and still advance PC.
REQ-034 When src equals dest, both ALU operand ports SHALL carry the same register value.

Reset
REQ-035 During nReset low: state IDLE, PC 0, all registers 0, flags 0, instruction register 0.
REQ-036 During nReset low: FetchRequest, Busy, IllegalOp and all Alu* outputs are 0.
REQ-037 Reset asserted mid-fetch SHALL drop FetchRequest immediately, and a late FetchAck SHALL be ignored.

Structure
REQ-038 InstructionWidth, the opcode/dest/src/immediate field positions and an sInstruction struct SHALL be added to InstructionSetPkg, alongside the existing eOperation, sFlags, DataWidth and ImmediateWidth.
REQ-039 The register file SHALL be a sub-module, register_file: two combinational read ports plus a debug read port, one synchronous write port, and asynchronous reset.

Verification
REQ-040 Reset, StartAddress=0x10, Start, memory acks in the same cycle, LIL r1,#5 -> FetchAddress=0x10, after WRITEBACK DebugAddr=1 gives DebugData=5, next FetchAddress=0x11.
REQ-041 FetchAck delayed 4 cycles -> FetchRequest high for 5 cycles with FetchAddress constant; no register changes.
REQ-042 LIL r1,#-1; ROL r3<-r1 with Carry=0 -> r3=-2, Carry=1, r1 unchanged.
REQ-043 StartAddress=2**AddressWidth-1, one MOVE -> next FetchAddress=0.
REQ-044 Undefined opcode -> IllegalOp high exactly one cycle, registers and flags unchanged, PC+1.
REQ-045 nReset low while FetchRequest is high, then a FetchAck -> FetchRequest=0, Busy=0, PC=0, state IDLE until the next Start.

Source files
------------

// File: rtl/instruction_sequencer_pkg.sv
// InstructionSetPkg: shared instruction-set definitions for the sequencer,
// its register file and the external ALU.
//   eOperation   - ALU operation codes (4-bit opcode field)
//   sFlags       - ALU condition flags {Negative, Zero, Carry, Overflow}
//   sInstruction - instruction word layout {opcode, dest, src, imm}
package InstructionSetPkg;

  localparam int DataWidth        = 8;
  localparam int ImmediateWidth   = 8;
  localparam int OpcodeWidth      = 4;
  localparam int RegFieldWidth    = 3;
  localparam int InstructionWidth = 18;

  // Bit positions of the fields inside an instruction word.
  localparam int OpcodeMsb = 17;
  localparam int OpcodeLsb = 14;
  localparam int DestMsb   = 13;
  localparam int DestLsb   = 11;
  localparam int SrcMsb    = 10;
  localparam int SrcLsb    = 8;
  localparam int ImmMsb    = 7;
  localparam int ImmLsb    = 0;

  typedef enum logic [OpcodeWidth-1:0] {
    OP_NOP  = 4'h0,
    OP_MOVE = 4'h1,
    OP_LIL  = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_XOR  = 4'h7,
    OP_ROL  = 4'h8,
    OP_ROR  = 4'h9
  } eOperation;

  typedef struct packed {
    logic Negative;
    logic Zero;
    logic Carry;
    logic Overflow;
  } sFlags;

  typedef struct packed {
    logic [OpcodeWidth-1:0]    opcode;
    logic [RegFieldWidth-1:0]  dest;
    logic [RegFieldWidth-1:0]  src;
    logic [ImmediateWidth-1:0] imm;
  } sInstruction;

  // Opcodes above OP_ROR have no defined behaviour.
  function automatic logic is_defined_op(input logic [OpcodeWidth-1:0] opcode);
    return (opcode <= 4'h9);
  endfunction

endpackage

// File: rtl/instruction_sequencer_register_file.sv
// register_file: 2**AddrWidth x DataWidth registers.
//   Clock, nReset         - clock, asynchronous active-low reset (clears all)
//   i_rd_addr_a/b         - combinational read ports (source / destination)
//   o_rd_data_a/b
//   i_dbg_addr/o_dbg_data - combinational debug read port
//   i_wr_en/addr/data     - synchronous write port
module register_file #(
  parameter int AddrWidth = 3,
  parameter int DataWidth = 8
) (
  input  logic                 Clock,
  input  logic                 nReset,
  input  logic [AddrWidth-1:0] i_rd_addr_a,
  output logic [DataWidth-1:0] o_rd_data_a,
  input  logic [AddrWidth-1:0] i_rd_addr_b,
  output logic [DataWidth-1:0] o_rd_data_b,
  input  logic [AddrWidth-1:0] i_dbg_addr,
  output logic [DataWidth-1:0] o_dbg_data,
  input  logic                 i_wr_en,
  input  logic [AddrWidth-1:0] i_wr_addr,
  input  logic [DataWidth-1:0] i_wr_data
);

  localparam int Depth = 2 ** AddrWidth;

  logic [DataWidth-1:0] r_regs [Depth];

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < Depth; i++) r_regs[i] <= '0;
    end else if (i_wr_en) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data_a = r_regs[i_rd_addr_a];
  assign o_rd_data_b = r_regs[i_rd_addr_b];
  assign o_dbg_data  = r_regs[i_dbg_addr];

endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: fetch / execute / writeback controller driving an
// external ALU from an internal register file and flags register.
//   Clock, nReset                  - clock, asynchronous active-low reset
//   Start, StartAddress, Stop      - run control
//   FetchRequest/Address/Ack/Data  - instruction memory handshake
//   AluOperation, AluIn*           - operands to ALU (zero unless executing)
//   AluOutDest, AluOutFlags        - ALU results, written back in WRITEBACK
//   Busy, IllegalOp                - status
//   DebugAddr, DebugData           - register file debug read
//
// state     | meaning
// IDLE      | waiting for Start
// FETCH     | FetchRequest high, PC on FetchAddress, wait for FetchAck
// EXECUTE   | ALU operands driven from instruction register
// WRITEBACK | ALU result/flags written on exit, PC advanced
module instruction_sequencer
  import InstructionSetPkg::*;
#(
  parameter int AddressWidth    = 8,
  parameter int RegAddressWidth = 3
) (
  input  logic                        Clock,
  input  logic                        nReset,
  input  logic                        Start,
  input  logic [AddressWidth-1:0]     StartAddress,
  input  logic                        Stop,
  output logic                        FetchRequest,
  output logic [AddressWidth-1:0]     FetchAddress,
  input  logic                        FetchAck,
  input  logic [InstructionWidth-1:0] FetchData,
  output eOperation                   AluOperation,
  output sFlags                       AluInFlags,
  output logic [ImmediateWidth-1:0]   AluInImm,
  output logic [DataWidth-1:0]        AluInSrc,
  output logic [DataWidth-1:0]        AluInDest,
  input  logic [DataWidth-1:0]        AluOutDest,
  input  sFlags                       AluOutFlags,
  output logic                        Busy,
  output logic                        IllegalOp,
  input  logic [RegAddressWidth-1:0]  DebugAddr,
  output logic [DataWidth-1:0]        DebugData
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_FETCH     = 2'd1,
    S_EXECUTE   = 2'd2,
    S_WRITEBACK = 2'd3
  } e_state;

  e_state                  r_state;
  logic [AddressWidth-1:0] r_pc;
  sInstruction             r_ir;
  sFlags                   r_flags;
  logic                    r_stop_seen;
  logic                    r_fetch_req;
  logic                    r_busy;
  logic                    r_illegal;

  logic                 w_alu_en;
  logic                 w_legal;
  logic                 w_wr_en;
  logic [DataWidth-1:0] w_src_data;
  logic [DataWidth-1:0] w_dest_data;

  assign w_legal  = is_defined_op(r_ir.opcode);
  assign w_alu_en = (r_state == S_EXECUTE) || (r_state == S_WRITEBACK);
  assign w_wr_en  = (r_state == S_WRITEBACK) && w_legal;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_ir        <= '0;
      r_flags     <= '0;
      r_stop_seen <= 1'b0;
      r_fetch_req <= 1'b0;
      r_busy      <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start && !Stop) begin
            r_pc        <= StartAddress;
            r_state     <= S_FETCH;
            r_fetch_req <= 1'b1;
            r_busy      <= 1'b1;
            r_stop_seen <= 1'b0;
          end
        end
        S_FETCH: begin
          if (Stop) r_stop_seen <= 1'b1;
          if (FetchAck) begin
            r_ir        <= sInstruction'(FetchData);
            r_fetch_req <= 1'b0;
            r_state     <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          if (Stop) r_stop_seen <= 1'b1;
          r_illegal <= !w_legal;
          r_state   <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          r_pc <= r_pc + AddressWidth'(1);
          if (w_legal) r_flags <= AluOutFlags;
          // Stop in this very cycle also counts as seen during the instruction.
          if (r_stop_seen || Stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state     <= S_FETCH;
            r_fetch_req <= 1'b1;
            r_stop_seen <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  register_file #(
    .AddrWidth (RegAddressWidth),
    .DataWidth (DataWidth)
  ) u_register_file (
    .Clock       (Clock),
    .nReset      (nReset),
    .i_rd_addr_a (RegAddressWidth'(r_ir.src)),
    .o_rd_data_a (w_src_data),
    .i_rd_addr_b (RegAddressWidth'(r_ir.dest)),
    .o_rd_data_b (w_dest_data),
    .i_dbg_addr  (DebugAddr),
    .o_dbg_data  (DebugData),
    .i_wr_en     (w_wr_en),
    .i_wr_addr   (RegAddressWidth'(r_ir.dest)),
    .i_wr_data   (AluOutDest)
  );

  // Raw opcode is passed through even when undefined; its results are discarded.
  assign AluOperation = w_alu_en ? eOperation'(r_ir.opcode) : OP_NOP;
  assign AluInFlags   = w_alu_en ? r_flags     : '0;
  assign AluInImm     = w_alu_en ? r_ir.imm    : '0;
  assign AluInSrc     = w_alu_en ? w_src_data  : '0;
  assign AluInDest    = w_alu_en ? w_dest_data : '0;

  assign FetchRequest = r_fetch_req;
  assign FetchAddress = r_pc;
  assign Busy         = r_busy;
  assign IllegalOp    = r_illegal;

endmodule

// File: tb/tb_instruction_sequencer.sv
module tb_instruction_sequencer;
  import InstructionSetPkg::*;

  logic        Clock;
  logic        nReset;
  logic        Start;
  logic [7:0]  StartAddress;
  logic        Stop;
  logic        FetchRequest;
  logic [7:0]  FetchAddress;
  logic        FetchAck;
  logic [17:0] FetchData;
  eOperation   AluOperation;
  sFlags       AluInFlags;
  logic [7:0]  AluInImm;
  logic [7:0]  AluInSrc;
  logic [7:0]  AluInDest;
  logic [7:0]  AluOutDest;
  sFlags       AluOutFlags;
  logic        Busy;
  logic        IllegalOp;
  logic [2:0]  DebugAddr;
  logic [7:0]  DebugData;

  instruction_sequencer #(.AddressWidth(8), .RegAddressWidth(3)) dut (
    .Clock(Clock), .nReset(nReset), .Start(Start), .StartAddress(StartAddress),
    .Stop(Stop), .FetchRequest(FetchRequest), .FetchAddress(FetchAddress),
    .FetchAck(FetchAck), .FetchData(FetchData), .AluOperation(AluOperation),
    .AluInFlags(AluInFlags), .AluInImm(AluInImm), .AluInSrc(AluInSrc),
    .AluInDest(AluInDest), .AluOutDest(AluOutDest), .AluOutFlags(AluOutFlags),
    .Busy(Busy), .IllegalOp(IllegalOp), .DebugAddr(DebugAddr), .DebugData(DebugData)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // External ALU reference model.
  logic [8:0] alu_sum;
  always_comb begin
    AluOutDest  = AluInDest;
    AluOutFlags = AluInFlags;
    alu_sum     = '0;
    case (AluOperation)
      OP_NOP:  ;
      OP_MOVE: AluOutDest = AluInSrc;
      OP_LIL:  AluOutDest = AluInImm;
      OP_ADD: begin
        alu_sum = {1'b0, AluInDest} + {1'b0, AluInSrc};
        AluOutDest = alu_sum[7:0];
        AluOutFlags.Carry = alu_sum[8];
      end
      OP_SUB: begin
        alu_sum = {1'b0, AluInDest} - {1'b0, AluInSrc};
        AluOutDest = alu_sum[7:0];
        AluOutFlags.Carry = alu_sum[8];
      end
      OP_AND: AluOutDest = AluInDest & AluInSrc;
      OP_OR:  AluOutDest = AluInDest | AluInSrc;
      OP_XOR: AluOutDest = AluInDest ^ AluInSrc;
      OP_ROL: begin
        AluOutDest = {AluInSrc[6:0], AluInFlags.Carry};
        AluOutFlags.Carry = AluInSrc[7];
      end
      OP_ROR: begin
        AluOutDest = {AluInFlags.Carry, AluInSrc[7:1]};
        AluOutFlags.Carry = AluInSrc[0];
      end
      default: begin
        AluOutDest  = 8'hA5;
        AluOutFlags = 4'hF;
      end
    endcase
    if (AluOperation != OP_NOP && AluOperation <= OP_ROR) begin
      AluOutFlags.Negative = AluOutDest[7];
      AluOutFlags.Zero     = (AluOutDest == 8'h00);
    end
  end

  // Instruction memory with programmable acknowledge delay.
  logic [17:0] mem [256];
  int          ack_delay;
  int          ack_cnt;
  logic        force_ack;

  initial begin
    FetchAck  = 1'b0;
    FetchData = '0;
    ack_cnt   = 0;
    forever begin
      @(negedge Clock);
      if (force_ack) begin
        FetchAck  = 1'b1;
        FetchData = mem[FetchAddress];
      end else if (FetchRequest) begin
        if (ack_cnt >= ack_delay) begin
          FetchAck  = 1'b1;
          FetchData = mem[FetchAddress];
          ack_cnt   = 0;
        end else begin
          FetchAck = 1'b0;
          ack_cnt++;
        end
      end else begin
        FetchAck = 1'b0;
        ack_cnt  = 0;
      end
    end
  end

  int checks;
  int failures;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] enc(input logic [3:0] op, input logic [2:0] d,
                                      input logic [2:0] s, input logic [7:0] imm);
    return {op, d, s, imm};
  endfunction

  // Results captured by run_one.
  logic [3:0] cap_op;
  logic [7:0] cap_src, cap_dest, cap_imm;
  logic [3:0] cap_flags;
  int         ill_cnt, fetch_cycles;
  logic       addr_bad, dbg_bad, run_done;

  // Runs a single instruction from addr; Stop is raised during FETCH so the
  // sequencer returns to IDLE after it.
  task automatic run_one(input logic [7:0] addr, input logic [17:0] instr, input logic [2:0] dbg);
    logic [7:0] dbg_before;
    logic       got_exec;
    mem[addr] = instr;
    DebugAddr = dbg;
    @(negedge Clock);
    Start = 1'b1; StartAddress = addr; Stop = 1'b0;
    dbg_before = DebugData;
    @(negedge Clock);
    Start = 1'b0; Stop = 1'b1;
    got_exec = 1'b0; run_done = 1'b0; ill_cnt = 0; fetch_cycles = 0;
    addr_bad = 1'b0; dbg_bad = 1'b0;
    cap_op = '0; cap_src = '0; cap_dest = '0; cap_imm = '0; cap_flags = '0;
    for (int c = 0; c < 60 && !run_done; c++) begin
      if (!Busy) run_done = 1'b1;
      else begin
        if (FetchRequest) begin
          fetch_cycles++;
          if (FetchAddress !== addr) addr_bad = 1'b1;
          if (DebugData !== dbg_before) dbg_bad = 1'b1;
        end else if (!got_exec) begin
          got_exec  = 1'b1;
          cap_op    = AluOperation;
          cap_src   = AluInSrc;
          cap_dest  = AluInDest;
          cap_imm   = AluInImm;
          cap_flags = AluInFlags;
        end
        if (IllegalOp) ill_cnt++;
        @(negedge Clock);
      end
    end
    Stop = 1'b0;
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [3:0] op;
    logic [2:0] dest;
    logic [2:0] src;
    logic [7:0] imm;
    logic [7:0] exp_src;
    logic [7:0] exp_dest;
    logic [3:0] exp_flags;
    logic [2:0] chk_reg;
    logic [7:0] exp_reg;
    int         exp_ill;
  } vec_t;

  vec_t vecs [13];

  initial begin
    logic [7:0] nxt;
    int busy_cycles, fetch_seen;
    logic stuck_bad;
    checks = 0; failures = 0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    ack_delay = 0; force_ack = 1'b0;
    nReset = 1'b0; Start = 1'b0; StartAddress = '0; Stop = 1'b0; DebugAddr = 3'd1;

    //            addr   op    d  s  imm    src    dest   NZCV     reg rval  ill
    vecs[0]  = '{8'h10, 4'h2, 1, 0, 8'h05, 8'h00, 8'h00, 4'b0000, 1, 8'h05, 0};
    vecs[1]  = '{8'h11, 4'h2, 2, 0, 8'h80, 8'h00, 8'h00, 4'b0000, 2, 8'h80, 0};
    vecs[2]  = '{8'h12, 4'h3, 2, 2, 8'h00, 8'h80, 8'h80, 4'b1000, 2, 8'h00, 0};
    vecs[3]  = '{8'h13, 4'h1, 3, 1, 8'h00, 8'h05, 8'h00, 4'b0110, 3, 8'h05, 0};
    vecs[4]  = '{8'h14, 4'h4, 3, 1, 8'h00, 8'h05, 8'h05, 4'b0010, 3, 8'h00, 0};
    vecs[5]  = '{8'h15, 4'h2, 1, 0, 8'hFF, 8'h00, 8'h05, 4'b0100, 1, 8'hFF, 0};
    vecs[6]  = '{8'h16, 4'h8, 3, 1, 8'h00, 8'hFF, 8'h00, 4'b1000, 3, 8'hFE, 0};
    vecs[7]  = '{8'h17, 4'h1, 4, 1, 8'h00, 8'hFF, 8'h00, 4'b1010, 4, 8'hFF, 0};
    vecs[8]  = '{8'h18, 4'hF, 5, 4, 8'h3C, 8'hFF, 8'h00, 4'b1010, 5, 8'h00, 1};
    vecs[9]  = '{8'h19, 4'h5, 6, 4, 8'h00, 8'hFF, 8'h00, 4'b1010, 6, 8'h00, 0};
    vecs[10] = '{8'h1A, 4'h6, 6, 1, 8'h00, 8'hFF, 8'h00, 4'b0110, 6, 8'hFF, 0};
    vecs[11] = '{8'h1B, 4'h9, 7, 5, 8'h00, 8'h00, 8'h00, 4'b1010, 7, 8'h80, 0};
    vecs[12] = '{8'hFF, 4'h0, 0, 0, 8'h00, 8'h00, 8'h00, 4'b1000, 7, 8'h80, 0};

    // Reset state.
    repeat (2) @(negedge Clock);
    check("rst_busy", Busy, 0);
    check("rst_fetchreq", FetchRequest, 0);
    check("rst_illegal", IllegalOp, 0);
    check("rst_pc", FetchAddress, 0);
    check("rst_aluop", AluOperation, 0);
    check("rst_alu_operands", {AluInSrc, AluInDest, AluInImm, 4'(AluInFlags)}, 0);
    check("rst_reg1", DebugData, 0);
    nReset = 1'b1;
    @(negedge Clock);

    for (int v = 0; v < 13; v++) begin
      run_one(vecs[v].addr, enc(vecs[v].op, vecs[v].dest, vecs[v].src, vecs[v].imm), vecs[v].chk_reg);
      nxt = vecs[v].addr + 8'd1;
      check($sformatf("v%0d_done", v), run_done, 1);
      check($sformatf("v%0d_aluop", v), cap_op, vecs[v].op);
      check($sformatf("v%0d_src", v), cap_src, vecs[v].exp_src);
      check($sformatf("v%0d_dest", v), cap_dest, vecs[v].exp_dest);
      check($sformatf("v%0d_imm", v), cap_imm, vecs[v].imm);
      check($sformatf("v%0d_flags_in", v), cap_flags, vecs[v].exp_flags);
      check($sformatf("v%0d_illegal_cycles", v), ill_cnt, vecs[v].exp_ill);
      check($sformatf("v%0d_fetch_cycles", v), fetch_cycles, 1);
      check($sformatf("v%0d_reg", v), DebugData, vecs[v].exp_reg);
      check($sformatf("v%0d_next_pc", v), FetchAddress, nxt);
      check($sformatf("v%0d_alu_idle_zero", v), {AluInSrc, AluInDest, AluInImm}, 0);
    end
    DebugAddr = 3'd1;
    @(negedge Clock);
    check("r1_after_table", DebugData, 8'hFF);

    // Delayed acknowledge: FETCH held for 5 cycles with stable address.
    ack_delay = 4;
    run_one(8'h40, enc(4'h2, 3'd2, 3'd0, 8'h33), 3'd2);
    check("dly_done", run_done, 1);
    check("dly_fetch_cycles", fetch_cycles, 5);
    check("dly_addr_stable", addr_bad, 0);
    check("dly_reg_stable_in_fetch", dbg_bad, 0);
    check("dly_reg2", DebugData, 8'h33);
    check("dly_next_pc", FetchAddress, 8'h41);
    ack_delay = 0;

    // Back-to-back instructions: 3 cycles each, Stop during the second fetch.
    mem[8'h50] = enc(4'h2, 3'd1, 3'd0, 8'h11);
    mem[8'h51] = enc(4'h2, 3'd2, 3'd0, 8'h22);
    @(negedge Clock);
    Start = 1'b1; StartAddress = 8'h50;
    @(negedge Clock);
    Start = 1'b0;
    busy_cycles = 0; fetch_seen = 0;
    for (int c = 0; c < 40 && Busy; c++) begin
      busy_cycles++;
      if (FetchRequest) fetch_seen++;
      if (fetch_seen == 2) Stop = 1'b1;
      @(negedge Clock);
    end
    Stop = 1'b0;
    check("b2b_busy_cycles", busy_cycles, 6);
    check("b2b_fetches", fetch_seen, 2);
    check("b2b_next_pc", FetchAddress, 8'h52);
    DebugAddr = 3'd1; #1;
    check("b2b_r1", DebugData, 8'h11);
    DebugAddr = 3'd2; #1;
    check("b2b_r2", DebugData, 8'h22);

    // Reset during fetch, then a stray acknowledge.
    ack_delay = 3;
    mem[8'h60] = enc(4'h2, 3'd1, 3'd0, 8'h77);
    DebugAddr = 3'd1;
    @(negedge Clock);
    Start = 1'b1; StartAddress = 8'h60;
    @(negedge Clock);
    Start = 1'b0;
    check("mid_fetch_req_before_reset", FetchRequest, 1);
    #2 nReset = 1'b0;
    #1;
    check("mid_rst_fetchreq", FetchRequest, 0);
    check("mid_rst_busy", Busy, 0);
    check("mid_rst_pc", FetchAddress, 0);
    force_ack = 1'b1;
    repeat (2) @(negedge Clock);
    nReset = 1'b1;
    stuck_bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clock);
      if (Busy || FetchRequest || FetchAddress != 8'h00 || AluOperation != OP_NOP) stuck_bad = 1'b1;
    end
    force_ack = 1'b0;
    check("post_rst_stays_idle", stuck_bad, 0);
    check("post_rst_r1_cleared", DebugData, 0);
    ack_delay = 0;
    run_one(8'h61, enc(4'h2, 3'd3, 3'd0, 8'h09), 3'd3);
    check("restart_done", run_done, 1);
    check("restart_r3", DebugData, 8'h09);
    check("restart_next_pc", FetchAddress, 8'h62);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
